// File: rtl/mps_intl_pkg.sv
// Shared constants for the MPS interlock input filter: channel counts,
// debounce counter width/default and the first-fault index width.
package mps_intl_pkg;

  localparam int DI_W        = 16;
  localparam int AI_W        = 17;
  localparam int DEB_W       = 16;
  // 10 us at 200 MHz
  localparam int DEB_CNT_DEF = 2000;
  localparam int FIRST_IDX_W = 5;

endpackage

// File: rtl/mps_debounce_ch.sv
// One input channel: 2-flop synchronizer, debounce counter and filtered bit.
// Filtered bit follows the synced level after it has differed for N cycles.
module mps_debounce_ch #(
  parameter int DEB_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_raw,
  input  logic [DEB_W-1:0] i_deb_cnt,
  output logic             o_filt
);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [DEB_W-1:0] lim;

  // A programmed length of 0 or 1 both mean a single-cycle filter.
  assign lim = (i_deb_cnt > DEB_W'(1)) ? (i_deb_cnt - DEB_W'(1)) : '0;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= lim) begin
      // >= so that lowering N below an in-flight count still toggles
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
    end
  end

  assign o_filt = filt_q;

endmodule

// File: rtl/mps_intl_input_filter.sv
// MPS front-end: debounced DI, masked sticky analog interlocks; MPS_INTL_FIRST_FAULT_EN adds first-fault capture.
// DI latency N+2, AI latch N+3, clear 1 cycle; no backpressure, outputs are levels.
module mps_intl_input_filter #(
  parameter int DI_W  = mps_intl_pkg::DI_W,
  parameter int AI_W  = mps_intl_pkg::AI_W,
  parameter int DEB_W = mps_intl_pkg::DEB_W
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [DI_W-1:0]                     i_raw_di,
  input  logic [AI_W-1:0]                     i_raw_ai,
  input  logic [DEB_W-1:0]                    i_deb_cnt,
  input  logic [AI_W-1:0]                     i_ai_mask,
  input  logic                                i_intl_clr,
  output logic [DI_W-1:0]                     o_ext_di,
  output logic [AI_W-1:0]                     o_analog_intl,
  output logic [mps_intl_pkg::FIRST_IDX_W-1:0] o_first_idx,
  output logic                                o_first_vld
);

  import mps_intl_pkg::*;

  logic [AI_W-1:0] filt_ai;
  logic [AI_W-1:0] set_vec;
  logic [AI_W-1:0] latch_q, latch_d;

  for (genvar g = 0; g < DI_W; g++) begin : g_di
    mps_debounce_ch #(.DEB_W(DEB_W)) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_raw     (i_raw_di[g]),
      .i_deb_cnt (i_deb_cnt),
      .o_filt    (o_ext_di[g])
    );
  end

  for (genvar g = 0; g < AI_W; g++) begin : g_ai
    mps_debounce_ch #(.DEB_W(DEB_W)) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_raw     (i_raw_ai[g]),
      .i_deb_cnt (i_deb_cnt),
      .o_filt    (filt_ai[g])
    );
  end

  // Set dominates clear, so an active fault cannot be cleared away.
  assign set_vec = filt_ai & ~i_ai_mask;
  assign latch_d = (latch_q & ~{AI_W{i_intl_clr}}) | set_vec;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      latch_q <= '0;
    end else begin
      latch_q <= latch_d;
    end
  end

  assign o_analog_intl = latch_q;

`ifdef MPS_INTL_FIRST_FAULT_EN
  logic [AI_W-1:0]        new_set;
  logic [FIRST_IDX_W-1:0] low_idx;
  logic                   any_new;
  logic [FIRST_IDX_W-1:0] first_idx_q;
  logic                   first_vld_q;

  // A bit counts as newly set unless it was already held and not being cleared.
  assign new_set = set_vec & ~(latch_q & ~{AI_W{i_intl_clr}});
  assign any_new = |new_set;

  always_comb begin
    low_idx = '0;
    for (int i = AI_W - 1; i >= 0; i--) begin
      if (new_set[i]) begin
        low_idx = FIRST_IDX_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
    end else if (i_intl_clr) begin
      first_vld_q <= any_new;
      if (any_new) begin
        first_idx_q <= low_idx;
      end
    end else if (!first_vld_q && any_new) begin
      first_vld_q <= 1'b1;
      first_idx_q <= low_idx;
    end
  end

  assign o_first_idx = first_idx_q;
  assign o_first_vld = first_vld_q;
`else
  assign o_first_idx = '0;
  assign o_first_vld = 1'b0;
`endif

endmodule
